// File: rtl/transpose_ctrl.sv
// -----------------------------------------------------------------------------
// transpose_ctrl
//
// Address sequencer for the double-buffered 8x8 transpose memory that sits
// between the row-DCT and the column-DCT. Rows from the row-DCT are written
// into one bank (row-write addresses). Meanwhile the other bank is drained
// column by column (column-read addresses). The two banks ping-pong, so one
// block fills while the previous block drains.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   clr         in   synchronous clear, same effect as reset
//   in_valid    in   row-DCT presents a row
//   in_ready    out  a row is accepted this cycle (when in_valid)
//   wr_en       out  transpose-memory write strobe (in_valid & in_ready)
//   wr_bank     out  bank being filled
//   wr_row      out  row index being written
//   out_valid   out  a column of the draining bank is on the read port
//   out_ready   in   column-DCT consumes the column this cycle
//   rd_bank     out  bank being drained
//   rd_col      out  column index being read (combinational memory read)
//   out_last    out  out_valid on the last column of a block
//   block_done  out  one-cycle pulse after the last column of a block is taken
//   bank_full   out  per-bank full flag, bit b = bank b
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and its payload stable until that edge.
// ready may depend on state and on clr, but never on the partner's valid.
// -----------------------------------------------------------------------------
module transpose_ctrl #(
  parameter int unsigned ROW_PERIOD = 4,
  parameter int unsigned N          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       wr_en,
  output logic       wr_bank,
  output logic [2:0] wr_row,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       rd_bank,
  output logic [2:0] rd_col,
  output logic       out_last,
  output logic       block_done,
  output logic [1:0] bank_full
);

  localparam logic [2:0] LAST_IDX = 3'(N - 1);
  // Loaded on each accepted row. The counter then keeps in_ready low for
  // ROW_PERIOD-1 further cycles.
  localparam logic [3:0] GAP_LOAD = 4'(ROW_PERIOD - 1);

  logic       r_wr_bank;
  logic       r_rd_bank;
  logic [2:0] r_wr_row;
  logic [2:0] r_rd_col;
  logic [1:0] r_bank_full;
  logic [3:0] r_gap_cnt;
  logic       r_block_done;

  logic       w_in_ready;
  logic       w_out_valid;
  logic       w_wr_acc;
  logic       w_rd_acc;
  logic       w_wr_last;
  logic       w_rd_last;
  logic [1:0] w_bank_full_nxt;

  // A bank is never written and read at the same time. The full flag blocks
  // writes to a full bank, and reads are only allowed from a full bank.
  assign w_in_ready  = !r_bank_full[r_wr_bank] && (r_gap_cnt == 4'd0) && !clr;
  assign w_out_valid = r_bank_full[r_rd_bank];
  assign w_wr_acc    = in_valid & w_in_ready;
  assign w_rd_acc    = w_out_valid & out_ready;
  assign w_wr_last   = w_wr_acc && (r_wr_row == LAST_IDX);
  assign w_rd_last   = w_rd_acc && (r_rd_col == LAST_IDX);

  // Set and clear hit different banks, so both can happen on the same edge
  // without losing either event.
  always_comb begin
    w_bank_full_nxt = r_bank_full;
    if (w_wr_last) w_bank_full_nxt[r_wr_bank] = 1'b1;
    if (w_rd_last) w_bank_full_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_wr_row     <= 3'd0;
      r_rd_col     <= 3'd0;
      r_bank_full  <= 2'b00;
      r_gap_cnt    <= 4'd0;
      r_block_done <= 1'b0;
    end else if (clr) begin
      // Partial and full blocks are discarded; no block_done is produced.
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_wr_row     <= 3'd0;
      r_rd_col     <= 3'd0;
      r_bank_full  <= 2'b00;
      r_gap_cnt    <= 4'd0;
      r_block_done <= 1'b0;
    end else begin
      r_bank_full  <= w_bank_full_nxt;
      r_block_done <= w_rd_last;

      if (w_wr_acc) begin
        r_gap_cnt <= GAP_LOAD;
      end else if (r_gap_cnt != 4'd0) begin
        r_gap_cnt <= r_gap_cnt - 4'd1;
      end

      if (w_wr_acc) begin
        if (w_wr_last) begin
          r_wr_row  <= 3'd0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_row  <= r_wr_row + 3'd1;
        end
      end

      if (w_rd_acc) begin
        if (w_rd_last) begin
          r_rd_col  <= 3'd0;
          r_rd_bank <= ~r_rd_bank;
        end else begin
          r_rd_col  <= r_rd_col + 3'd1;
        end
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign wr_en      = w_wr_acc;
  assign wr_bank    = r_wr_bank;
  assign wr_row     = r_wr_row;
  assign out_valid  = w_out_valid;
  assign rd_bank    = r_rd_bank;
  assign rd_col     = r_rd_col;
  assign out_last   = w_out_valid && (r_rd_col == LAST_IDX);
  assign block_done = r_block_done;
  assign bank_full  = r_bank_full;

endmodule

// File: tb/tb_transpose_ctrl.sv
// -----------------------------------------------------------------------------
// tb_transpose_ctrl
//
// Three controllers with different row cadences share the clock, reset and
// clear: index 0 uses ROW_PERIOD=4, index 1 uses ROW_PERIOD=1 and index 2
// uses ROW_PERIOD=3. Cycle 0 is the first cycle after reset is released.
// Inputs change 1 time unit after a rising edge. Outputs are sampled on the
// falling edge. When a test drives the 8th row of a block, the expected column
// reads {bank, col} go into exp_q. Each read accept pops one entry.
// -----------------------------------------------------------------------------
module tb_transpose_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic [2:0] in_valid, out_ready;
  logic [2:0] in_ready, wr_en, wr_bank, out_valid, rd_bank, out_last, block_done;
  logic [2:0] wr_row [3];
  logic [2:0] rd_col [3];
  logic [1:0] bank_full [3];

  int         total = 0;
  int         bad = 0;
  logic [3:0] exp_q[$];
  logic       done_exp;

  always #5 clk = ~clk;

  transpose_ctrl #(.ROW_PERIOD(4)) u_rp4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .wr_en(wr_en[0]), .wr_bank(wr_bank[0]), .wr_row(wr_row[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .rd_bank(rd_bank[0]), .rd_col(rd_col[0]), .out_last(out_last[0]),
    .block_done(block_done[0]), .bank_full(bank_full[0]));

  transpose_ctrl #(.ROW_PERIOD(1)) u_rp1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .wr_en(wr_en[1]), .wr_bank(wr_bank[1]), .wr_row(wr_row[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .rd_bank(rd_bank[1]), .rd_col(rd_col[1]), .out_last(out_last[1]),
    .block_done(block_done[1]), .bank_full(bank_full[1]));

  transpose_ctrl #(.ROW_PERIOD(3)) u_rp3 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .wr_en(wr_en[2]), .wr_bank(wr_bank[2]), .wr_row(wr_row[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .rd_bank(rd_bank[2]), .rd_col(rd_col[2]), .out_last(out_last[2]),
    .block_done(block_done[2]), .bank_full(bank_full[2]));

  // ---------------------------------------------------------------- drivers
  task automatic do_reset();
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    exp_q.delete();
    done_exp  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic push_block(input logic bank);
    for (int col = 0; col < 8; col++) exp_q.push_back({bank, 3'(col)});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({wr_bank[i], rd_bank[i], wr_row[i], rd_col[i], bank_full[i], block_done[i],
           out_valid[i], out_last[i], wr_en[i], in_ready[i]} !== 15'b0_0_000_000_00_0_0_0_0_1) begin
        bad++;
        $display("FAIL reset_values inst=%0d got wb=%b rb=%b wr=%0d rc=%0d bf=%b bd=%b ov=%b ol=%b we=%b ir=%b required all 0 and ir=1",
                 i, wr_bank[i], rd_bank[i], wr_row[i], rd_col[i], bank_full[i], block_done[i],
                 out_valid[i], out_last[i], wr_en[i], in_ready[i]);
      end
    end
    next_cycle();
  endtask

  task automatic test_single_block();
    do_reset();
    out_ready[0] = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      in_valid[0] = (c <= 28);
      @(negedge clk);
      total++;
      if (wr_en[0] !== (c <= 28 && c % 4 == 0)) begin
        bad++; $display("FAIL single_wr_en c=%0d got=%b required=%b", c, wr_en[0], (c <= 28 && c % 4 == 0));
      end
      total++;
      if (in_ready[0] !== (c % 4 == 0 || c >= 32)) begin
        bad++; $display("FAIL single_in_ready c=%0d got=%b required=%b", c, in_ready[0], (c % 4 == 0 || c >= 32));
      end
      if (c <= 28) begin
        total++;
        if ({wr_bank[0], wr_row[0]} !== {1'b0, 3'((c + 3) / 4)}) begin
          bad++; $display("FAIL single_wr_addr c=%0d got=%b/%0d required=0/%0d", c, wr_bank[0], wr_row[0], (c + 3) / 4);
        end
      end
      total++;
      if (bank_full[0] !== ((c >= 29 && c <= 36) ? 2'b01 : 2'b00)) begin
        bad++; $display("FAIL single_bank_full c=%0d got=%b", c, bank_full[0]);
      end
      // scoreboard
      total++;
      if (out_valid[0] !== (exp_q.size() != 0)) begin
        bad++; $display("FAIL sb_out_valid c=%0d got=%b required=%b", c, out_valid[0], exp_q.size() != 0);
      end
      total++;
      if (block_done[0] !== done_exp) begin
        bad++; $display("FAIL sb_block_done c=%0d got=%b required=%b", c, block_done[0], done_exp);
      end
      if (exp_q.size() != 0) begin
        total++;
        if ({rd_bank[0], rd_col[0], out_last[0]} !== {exp_q[0], exp_q[0][2:0] == 3'd7}) begin
          bad++; $display("FAIL sb_read c=%0d got=%b/%0d/%b required=%h", c, rd_bank[0], rd_col[0], out_last[0], exp_q[0]);
        end
        done_exp = out_ready[0] && (exp_q[0][2:0] == 3'd7);
        if (out_ready[0]) void'(exp_q.pop_front());
      end else done_exp = 1'b0;
      next_cycle();
      if (c == 28) push_block(1'b0);
    end
  endtask

  task automatic test_backpressure_stall();
    logic [1:0] bf_exp;
    do_reset();
    for (int c = 0; c <= 78; c++) begin
      in_valid[1]  = (c <= 28);
      if (c <= 28) out_ready[1] = (c >= 20 && c <= 27);
      else         out_ready[1] = (c >= 70) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (c <= 28) begin
        total++;
        if ({wr_en[1], in_ready[1]} !== {2{(c < 16 || c == 28)}}) begin
          bad++; $display("FAIL bp_wr_en_in_ready c=%0d got=%b%b required=%b", c, wr_en[1], in_ready[1], (c < 16 || c == 28));
        end
        bf_exp = (c < 8) ? 2'b00 : (c < 16) ? 2'b01 : (c <= 27) ? 2'b11 : 2'b10;
      end else begin
        bf_exp = {exp_q.size() != 0, 1'b0};
      end
      total++;
      if (bank_full[1] !== bf_exp) begin
        bad++; $display("FAIL bp_bank_full c=%0d got=%b required=%b", c, bank_full[1], bf_exp);
      end
      if (c == 28) begin
        total++;
        if (wr_bank[1] !== 1'b0) begin
          bad++; $display("FAIL bp_wr_bank_after_drain got=%b required=0", wr_bank[1]);
        end
      end
      // scoreboard
      total++;
      if (out_valid[1] !== (exp_q.size() != 0)) begin
        bad++; $display("FAIL sb_out_valid c=%0d got=%b required=%b", c, out_valid[1], exp_q.size() != 0);
      end
      total++;
      if (block_done[1] !== done_exp) begin
        bad++; $display("FAIL sb_block_done c=%0d got=%b required=%b", c, block_done[1], done_exp);
      end
      if (exp_q.size() != 0) begin
        total++;
        if ({rd_bank[1], rd_col[1], out_last[1]} !== {exp_q[0], exp_q[0][2:0] == 3'd7}) begin
          bad++; $display("FAIL sb_read c=%0d got=%b/%0d/%b required=%h", c, rd_bank[1], rd_col[1], out_last[1], exp_q[0]);
        end
        done_exp = out_ready[1] && (exp_q[0][2:0] == 3'd7);
        if (out_ready[1]) void'(exp_q.pop_front());
      end else done_exp = 1'b0;
      next_cycle();
      if (c == 7)  push_block(1'b0);
      if (c == 15) push_block(1'b1);
    end
  endtask

  task automatic test_simultaneous();
    int ndone = 0;
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      in_valid[1]  = (c <= 15);
      out_ready[1] = (c >= 8 && c <= 15);
      @(negedge clk);
      total++;
      if (wr_en[1] !== (c <= 15)) begin
        bad++; $display("FAIL sim_wr_en c=%0d got=%b required=%b", c, wr_en[1], (c <= 15));
      end
      if (c == 15) begin
        total++;
        if (bank_full[1] !== 2'b01) begin
          bad++; $display("FAIL sim_bank_full_before got=%b required=01", bank_full[1]);
        end
      end
      if (c == 16) begin
        total++;
        if ({bank_full[1], rd_bank[1], wr_bank[1], in_ready[1]} !== 5'b10_1_0_1) begin
          bad++; $display("FAIL sim_after got bf=%b rb=%b wb=%b ir=%b required bf=10 rb=1 wb=0 ir=1",
                          bank_full[1], rd_bank[1], wr_bank[1], in_ready[1]);
        end
      end
      if (block_done[1] === 1'b1) ndone++;
      // scoreboard
      total++;
      if (out_valid[1] !== (exp_q.size() != 0)) begin
        bad++; $display("FAIL sb_out_valid c=%0d got=%b required=%b", c, out_valid[1], exp_q.size() != 0);
      end
      total++;
      if (block_done[1] !== done_exp) begin
        bad++; $display("FAIL sb_block_done c=%0d got=%b required=%b", c, block_done[1], done_exp);
      end
      if (exp_q.size() != 0) begin
        total++;
        if ({rd_bank[1], rd_col[1], out_last[1]} !== {exp_q[0], exp_q[0][2:0] == 3'd7}) begin
          bad++; $display("FAIL sb_read c=%0d got=%b/%0d/%b required=%h", c, rd_bank[1], rd_col[1], out_last[1], exp_q[0]);
        end
        done_exp = out_ready[1] && (exp_q[0][2:0] == 3'd7);
        if (out_ready[1]) void'(exp_q.pop_front());
      end else done_exp = 1'b0;
      next_cycle();
      if (c == 7)  push_block(1'b0);
      if (c == 15) push_block(1'b1);
    end
    total++;
    if (ndone != 1) begin
      bad++; $display("FAIL sim_block_done_count got=%0d required=1", ndone);
    end
  endtask

  task automatic test_clear();
    do_reset();
    in_valid[1] = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      total++;
      if (wr_en[1] !== 1'b1) begin
        bad++; $display("FAIL clr_fill_wr_en c=%0d got=%b required=1", c, wr_en[1]);
      end
      next_cycle();
    end
    clr = 1'b1;
    @(negedge clk);
    total++;
    if ({in_ready[1], wr_en[1], out_valid[1], wr_bank[1], wr_row[1], bank_full[1]} !== 9'b0_0_1_1_101_01) begin
      bad++; $display("FAIL clr_cycle got ir=%b we=%b ov=%b wb=%b wr=%0d bf=%b required ir=0 we=0 ov=1 wb=1 wr=5 bf=01",
                      in_ready[1], wr_en[1], out_valid[1], wr_bank[1], wr_row[1], bank_full[1]);
    end
    next_cycle();
    clr = 1'b0;
    in_valid[1] = 1'b0;
    for (int c = 14; c <= 19; c++) begin
      @(negedge clk);
      total++;
      if ({wr_bank[1], rd_bank[1], wr_row[1], rd_col[1], bank_full[1], block_done[1],
           out_valid[1], out_last[1], wr_en[1], in_ready[1]} !== 15'b0_0_000_000_00_0_0_0_0_1) begin
        bad++;
        $display("FAIL clr_after c=%0d got wb=%b rb=%b wr=%0d rc=%0d bf=%b bd=%b ov=%b ol=%b we=%b ir=%b",
                 c, wr_bank[1], rd_bank[1], wr_row[1], rd_col[1], bank_full[1], block_done[1],
                 out_valid[1], out_last[1], wr_en[1], in_ready[1]);
      end
      next_cycle();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      in_valid[1]  = (c <= 7);
      out_ready[1] = (c >= 8);
      @(negedge clk);
      // scoreboard
      total++;
      if (out_valid[1] !== (exp_q.size() != 0)) begin
        bad++; $display("FAIL sb_out_valid c=%0d got=%b required=%b", c, out_valid[1], exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        total++;
        if ({rd_bank[1], rd_col[1], out_last[1]} !== {exp_q[0], exp_q[0][2:0] == 3'd7}) begin
          bad++; $display("FAIL sb_read c=%0d got=%b/%0d/%b required=%h", c, rd_bank[1], rd_col[1], out_last[1], exp_q[0]);
        end
        if (out_ready[1]) void'(exp_q.pop_front());
      end
      next_cycle();
      if (c == 7) push_block(1'b0);
    end
    // Mid-read (rd_col=3): assert reset between edges and sample before any edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({wr_bank[1], rd_bank[1], wr_row[1], rd_col[1], bank_full[1], block_done[1],
         out_valid[1], out_last[1], wr_en[1]} !== 14'b0) begin
      bad++;
      $display("FAIL async_reset got wb=%b rb=%b wr=%0d rc=%0d bf=%b bd=%b ov=%b ol=%b we=%b required all 0",
               wr_bank[1], rd_bank[1], wr_row[1], rd_col[1], bank_full[1], block_done[1],
               out_valid[1], out_last[1], wr_en[1]);
    end
    next_cycle();
    rst_n = 1'b1;
    exp_q.delete();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if ({block_done[1], out_valid[1], in_ready[1]} !== 3'b001) begin
        bad++; $display("FAIL async_after c=%0d got bd=%b ov=%b ir=%b required 0 0 1", c, block_done[1], out_valid[1], in_ready[1]);
      end
      next_cycle();
    end
  endtask

  task automatic test_gap();
    int nwr0 = 0;
    int nwr1 = 0;
    do_reset();
    out_ready[2] = 1'b1;
    for (int c = 0; c <= 56; c++) begin
      in_valid[2] = (c <= 45);
      @(negedge clk);
      total++;
      if (wr_en[2] !== (c <= 45 && c % 3 == 0)) begin
        bad++; $display("FAIL gap_wr_en c=%0d got=%b required=%b", c, wr_en[2], (c <= 45 && c % 3 == 0));
      end
      if (wr_en[2] === 1'b1) begin
        if (wr_bank[2] === 1'b1) nwr1++;
        else                     nwr0++;
      end
      // scoreboard
      total++;
      if (out_valid[2] !== (exp_q.size() != 0)) begin
        bad++; $display("FAIL sb_out_valid c=%0d got=%b required=%b", c, out_valid[2], exp_q.size() != 0);
      end
      total++;
      if (block_done[2] !== done_exp) begin
        bad++; $display("FAIL sb_block_done c=%0d got=%b required=%b", c, block_done[2], done_exp);
      end
      if (exp_q.size() != 0) begin
        total++;
        if ({rd_bank[2], rd_col[2], out_last[2]} !== {exp_q[0], exp_q[0][2:0] == 3'd7}) begin
          bad++; $display("FAIL sb_read c=%0d got=%b/%0d/%b required=%h", c, rd_bank[2], rd_col[2], out_last[2], exp_q[0]);
        end
        done_exp = out_ready[2] && (exp_q[0][2:0] == 3'd7);
        if (out_ready[2]) void'(exp_q.pop_front());
      end else done_exp = 1'b0;
      next_cycle();
      if (c == 21) push_block(1'b0);
      if (c == 45) push_block(1'b1);
    end
    total++;
    if (nwr0 != 8 || nwr1 != 8) begin
      bad++; $display("FAIL gap_writes_per_block got=%0d/%0d required=8/8", nwr0, nwr1);
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_backpressure_stall();
    test_simultaneous();
    test_clear();
    test_async_reset();
    test_gap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/transpose_ctrl.md
Name: transpose_ctrl

Overview:
Sequencer for the double-buffered 8x8 transpose memory between the row-DCT and column-DCT stages of the JPEG accelerator. It accepts 12-bit-per-element rows from the row DCT through a valid/ready handshake and generates the row-write addresses. It then generates column-read addresses for the column DCT, also through valid/ready. It ping-pongs between two banks, so one block can fill while the previous block drains.

Parameters:
ROW_PERIOD, 4, minimum clock cycles between two accepted rows (row-DCT cadence); legal range 1..15
N, 8, rows/columns per block; fixed at 8 (counters are 3 bits)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
clr  in  1  synchronous clear; same effect as reset, one cycle
in_valid  in  1  row-DCT has a row on the datapath
in_ready  out  1  controller accepts a row this cycle
wr_en  out  1  write strobe to transpose memory (= in_valid & in_ready)
wr_bank  out  1  bank being filled
wr_row  out  3  row index for the write
out_valid  out  1  a column is available on the memory read port
out_ready  in  1  column-DCT consumes the column this cycle
rd_bank  out  1  bank being drained
rd_col  out  3  column index for the read; memory read is combinational, so data is valid in the same cycle
out_last  out  1  out_valid & (rd_col == 7)
block_done  out  1  one-cycle pulse, registered, the cycle after the 8th column of a block is consumed
bank_full  out  2  per-bank full flag (bit b = bank b)

Behaviour:
- Reset or clr gives the following values:
  - wr_bank=0, rd_bank=0, wr_row=0, rd_col=0
  - bank_full=00, gap_cnt=0, block_done=0
  - out_valid=0, out_last=0, wr_en=0
  - in_ready=1 after rst_n deasserts. in_ready is 0 during any cycle with clr=1.
  - clr or reset mid-block discards all partial and full blocks; no block_done is produced.
- in_ready = !bank_full[wr_bank] & (gap_cnt==0) & !clr.
- Write accept occurs when in_valid & in_ready:
  - wr_row increments.
  - gap_cnt loads ROW_PERIOD-1; it decrements to 0 on each subsequent cycle, and in_ready stays low while gap_cnt is nonzero.
  - With ROW_PERIOD=1, rows can be accepted back-to-back.
- Accepting row 7: bank_full[wr_bank] is set, wr_row wraps to 0 and wr_bank toggles, all on the same edge.
- out_valid = bank_full[rd_bank].
- Read accept occurs when out_valid & out_ready:
  - rd_col increments.
  - On column 7: bank_full[rd_bank] clears, rd_col wraps to 0, rd_bank toggles, and block_done pulses the next cycle.
- Simultaneous events:
  - Write of row 7 into bank A and read of column 7 from bank B in the same cycle both take effect. Both flags update independently, with no lost event.
  - A write to a bank can never coincide with its own read, because full gates both sides.
- With both banks full, in_ready=0 until a bank drains. The first in_ready after the drain is in the cycle following the column-7 accept, provided gap_cnt==0.
- out_valid, rd_col and rd_bank must hold stable while out_ready=0.
- Latency: a block's last row is accepted on edge t, so out_valid=1 in cycle t+1 (first column available). Minimum block turnaround is 8 read cycles.
- in_valid is ignored while in_ready=0. Upstream must hold its row until accepted.

Test Plan:
- Single block, ROW_PERIOD=4, in_valid held high:
  - accepts occur at cycles 0, 4, 8 … 28; wr_row runs 0..7 on bank 0.
  - out_valid rises in cycle 29 with rd_bank=0.
  - with out_ready=1, rd_col runs 0..7 over cycles 29..36; out_last=1 in cycle 36 only.
  - block_done pulses in cycle 37; bank_full returns to 00.
- Backpressure, ROW_PERIOD=1, out_ready=0:
  - 16 rows accepted back-to-back; bank_full=11 and in_ready=0 from cycle 16.
  - out_ready asserted for 8 cycles: bank 0 drains, and in_ready=1 the cycle after the column-7 accept, with wr_bank=0.
- Simultaneous completion: align the 8th write to bank 1 with the 8th read of bank 0 on the same edge.
  - bank_full goes 01 -> 10; rd_bank=1, wr_bank=0; block_done pulses exactly once.
- Stall stability: with bank full, toggle out_ready randomly.
  - rd_col advances only on accepted cycles; rd_col, rd_bank and out_valid never change while out_ready=0.
- Clear mid-operation: assert clr for one cycle after 5 rows into bank 1 with bank 0 full.
  - all outputs return to reset values next cycle; no block_done is produced.
  - async rst_n asserted mid-read gives the same result immediately, without waiting for a clock edge.
- Gap enforcement, ROW_PERIOD=3, in_valid pulsed every cycle:
  - wr_en is asserted only every 3rd cycle; exactly 8 wr_en per block.
